freq_div_ctrl: RTL and testbench

Controller for a programmable even-ratio clock divider. Accepts divide-ratio updates over a valid/ready handshake and starts/stops the divided output on request. Applies every change only at a period boundary, so out_clk never produces a runt pulse. Sits between a register/config master and any logic clocked by the divided enable/clock.

---
 rtl/freq_div_pkg.sv | 14 +
 rtl/freq_div_core.sv | 47 ++++
 rtl/freq_div_ctrl.sv | 137 +++++++++++++
 tb/tb_freq_div_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types and defaults for the even-ratio clock divider controller.
// Optional macro: FREQ_DIV_PCNT_EN (completed-period counter on the top).
package freq_div_pkg;

    localparam int FD_DIV_W        = 16;
    localparam int FD_DEFAULT_HALF = 16384;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/freq_div_core.sv
// Half-period counter and out_clk toggle register.
// Macro FREQ_DIV_PCNT_EN is handled by the top, not here.
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int DIV_W = FD_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_half,
    output logic             o_out_clk,
    output logic             o_rise,
    output logic             o_fall
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_out;
    logic             w_last;

    assign w_last = (r_cnt == i_half - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (i_run) begin
            if (w_last) begin
                r_cnt <= '0;
                r_out <= ~r_out;
            end else begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign o_out_clk = r_out;
    assign o_rise    = i_run & w_last & ~r_out;
    assign o_fall    = i_run & w_last & r_out;

endmodule

// File: rtl/freq_div_ctrl.sv
// Run/stop FSM, config handshake and shadow ratio for the divider.
// Macro FREQ_DIV_PCNT_EN adds the pcnt completed-period output.
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int DIV_W        = FD_DIV_W,
    parameter int DEFAULT_HALF = FD_DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_req,
    input  logic             stop_req,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             out_clk,
    output logic             tick,
    output logic             busy
`ifdef FREQ_DIV_PCNT_EN
    ,
    output logic [31:0]      pcnt
`endif
);

    localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF);

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_active_half;
    logic [DIV_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_err;
    logic             r_tick;

    logic w_run;
    logic w_clear;
    logic w_rise;
    logic w_fall;
    logic w_xfer;
    logic w_zero;
    logic w_enter_idle;
    logic w_apply;
    logic w_direct;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (en_req && !stop_req)
                    w_next = RUN;
            end
            RUN: begin
                // a stop landing on the falling edge needs no STOPPING phase
                if (stop_req)
                    w_next = (!out_clk || w_fall) ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (w_fall)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_run        = (r_state != IDLE);
    assign w_clear      = (w_next == IDLE);
    assign w_enter_idle = w_run && (w_next == IDLE);
    assign w_apply      = r_pending && (w_fall || w_enter_idle);
    assign w_xfer       = cfg_valid && cfg_ready;
    assign w_zero       = (cfg_half == '0);
    assign w_direct     = (r_state == IDLE) || w_enter_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_half <= RST_HALF;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_err         <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_err  <= w_xfer && w_zero;
            r_tick <= w_rise && !w_clear;
            if (w_apply) begin
                r_active_half <= r_shadow;
                r_pending     <= 1'b0;
            end
            if (w_xfer && !w_zero) begin
                if (w_direct) begin
                    r_active_half <= cfg_half;
                end else begin
                    r_shadow  <= cfg_half;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    freq_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_run),
        .i_clear  (w_clear),
        .i_half   (r_active_half),
        .o_out_clk(out_clk),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

`ifdef FREQ_DIV_PCNT_EN
    logic [31:0] r_pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pcnt <= '0;
        else if (w_fall)
            r_pcnt <= r_pcnt + 32'd1;
    end

    assign pcnt = r_pcnt;
`endif

    assign cfg_ready = !r_pending;
    assign cfg_err   = r_err;
    assign tick      = r_tick;
    assign busy      = w_run;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed bench for freq_div_ctrl: tick times via a queue, levels per cycle.
// Build with FREQ_DIV_PCNT_EN to also check pcnt.
module tb_freq_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_req;
    logic        stop_req;
    logic        cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready;
    logic        cfg_err;
    logic        out_clk;
    logic        tick;
    logic        busy;
`ifdef FREQ_DIV_PCNT_EN
    logic [31:0] pcnt;
`endif

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int g_E;
    int g_h;
    int pc_base;
    int q[$];

    freq_div_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en_req   (en_req),
        .stop_req (stop_req),
        .cfg_valid(cfg_valid),
        .cfg_half (cfg_half),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .out_clk  (out_clk),
        .tick     (tick),
        .busy     (busy)
`ifdef FREQ_DIV_PCNT_EN
        ,
        .pcnt     (pcnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // every observed tick must match the next scheduled tick cycle
    always @(negedge clk) begin
        if (tick) begin
            if (q.size() == 0)
                chk("tick_unexpected", 32'(tick), 0);
            else
                chk("tick_cycle", cyc, q.pop_front());
        end
    end

    task automatic chk_rst(input string tag);
        chk({tag, "_out_clk"}, 32'(out_clk), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
`ifdef FREQ_DIV_PCNT_EN
        chk({tag, "_pcnt"}, pcnt, 0);
`endif
    endtask

    task automatic load_cfg(input int v);
        chk("cfg_ready_idle", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_half  = 16'(v);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic start_run(input int h);
        en_req = 1'b1;
        g_E    = cyc + 1;
        g_h    = h;
        @(negedge clk);
        en_req = 1'b0;
    endtask

    task automatic push_ticks(input int jmax);
        for (int j = g_h; j <= jmax; j += 2 * g_h)
            q.push_back(g_E + j);
    endtask

    task automatic watch(input int n);
        int j;
        for (int k = 0; k < n; k++) begin
            j = cyc - g_E;
            chk("run_out_clk", 32'(out_clk), (j / g_h) % 2);
            chk("run_busy", 32'(busy), 1);
`ifdef FREQ_DIV_PCNT_EN
            chk("run_pcnt", pcnt, pc_base + j / (2 * g_h));
`endif
            @(negedge clk);
        end
    endtask

    task automatic stop_low(input int pc);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        chk("stop_low_busy", 32'(busy), 0);
        chk("stop_low_out", 32'(out_clk), 0);
`ifdef FREQ_DIV_PCNT_EN
        chk("stop_low_pcnt", pcnt, pc);
`endif
    endtask

    initial begin
        int j;
        int eo;
        rst       = 1'b1;
        en_req    = 1'b0;
        stop_req  = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        pc_base   = 0;
        repeat (2) @(negedge clk);
        chk_rst("reset");
        rst = 1'b0;
        @(negedge clk);

        // default ratio: 16384 high / 16384 low, then stop while low
        start_run(16384);
        push_ticks(2 * 16384 + 1);
        watch(2 * 16384 + 2);
        stop_low(1);
        pc_base = 1;

        // half=3 loaded in IDLE
        load_cfg(3);
        start_run(3);
        push_ticks(23);
        watch(24);
        stop_low(5);
        pc_base = 5;

        // half=4, offer 2 mid-high phase
        load_cfg(4);
        start_run(4);
        push_ticks(13);
        watch(13);
        chk("reload_ready_pre", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_half  = 16'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        q.push_back(g_E + 18);
        q.push_back(g_E + 22);
        for (int k = 0; k < 10; k++) begin
            j  = cyc - g_E;
            eo = (j < 16) ? 1 : ((j - 16) / 2) % 2;
            chk("reload_out_clk", 32'(out_clk), eo);
            chk("reload_ready", 32'(cfg_ready), (j >= 16) ? 1 : 0);
`ifdef FREQ_DIV_PCNT_EN
            chk("reload_pcnt", pcnt,
                pc_base + ((j < 16) ? 1 : 2 + (j - 16) / 4));
`endif
            @(negedge clk);
        end
        stop_low(9);
        pc_base = 9;

        // half=5, stop while high; en_req ignored while stopping
        load_cfg(5);
        start_run(5);
        push_ticks(6);
        watch(7);
        stop_req = 1'b1;
        @(negedge clk);
        stop_req = 1'b0;
        en_req   = 1'b1;
        chk("stopping_busy_a", 32'(busy), 1);
        chk("stopping_out_a", 32'(out_clk), 1);
        @(negedge clk);
        en_req = 1'b0;
        chk("stopping_busy_b", 32'(busy), 1);
        chk("stopping_out_b", 32'(out_clk), 1);
        @(negedge clk);
        chk("stopped_busy_a", 32'(busy), 0);
        chk("stopped_out_a", 32'(out_clk), 0);
`ifdef FREQ_DIV_PCNT_EN
        chk("stopped_pcnt", pcnt, 10);
`endif
        @(negedge clk);
        chk("stopped_busy_b", 32'(busy), 0);
        chk("stopped_out_b", 32'(out_clk), 0);
        pc_base = 10;

        // zero half rejected, ratio kept at 5
        chk("zero_ready", 32'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_half  = 16'd0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("zero_err_pulse", 32'(cfg_err), 1);
        @(negedge clk);
        chk("zero_err_clear", 32'(cfg_err), 0);
        start_run(5);
        push_ticks(10);
        watch(11);
        stop_low(11);
        pc_base = 11;

        // en_req with stop_req in IDLE stays idle
        en_req   = 1'b1;
        stop_req = 1'b1;
        @(negedge clk);
        en_req   = 1'b0;
        stop_req = 1'b0;
        chk("en_stop_busy_a", 32'(busy), 0);
        @(negedge clk);
        chk("en_stop_busy_b", 32'(busy), 0);
        chk("en_stop_out", 32'(out_clk), 0);

        // reset during STOPPING with a pending ratio
        load_cfg(4);
        start_run(4);
        push_ticks(4);
        watch(5);
        cfg_valid = 1'b1;
        cfg_half  = 16'd7;
        stop_req  = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        stop_req  = 1'b0;
        chk("pend_ready", 32'(cfg_ready), 0);
        chk("pend_busy", 32'(busy), 1);
        chk("pend_out", 32'(out_clk), 1);
        rst = 1'b1;
        #1;
        chk_rst("midrst");
        @(negedge clk);
        rst = 1'b0;
        pc_base = 0;

        // ratio back at default after reset
        start_run(16384);
        push_ticks(16384);
        watch(16385);
        rst = 1'b1;
        #1;
        chk_rst("rst2");
        @(negedge clk);
        rst = 1'b0;

        // period counting restarts from zero
        load_cfg(2);
        start_run(2);
        push_ticks(12);
        watch(13);
        stop_low(3);

        chk("tick_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
